// File: rtl/isa_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : isa_bridge_pkg                                         |
// | Description : Shared constants and types for the ISA I/O bridge:     |
// |               register word addresses, CTRL/STATUS bit positions,    |
// |               the cycle-sequencer state encoding and a small helper  |
// |               that turns a programmed length into a down-count load. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package isa_bridge_pkg;

  // Register word addresses
  localparam logic [2:0] c_REG_DOUT     = 3'd0;
  localparam logic [2:0] c_REG_ADDR     = 3'd1;
  localparam logic [2:0] c_REG_CTRL     = 3'd2;
  localparam logic [2:0] c_REG_TIMING   = 3'd3;
  localparam logic [2:0] c_REG_STATUS   = 3'd4;
  localparam logic [2:0] c_REG_DIN      = 3'd5;
  localparam logic [2:0] c_REG_IRQ_PEND = 3'd6;
  localparam logic [2:0] c_REG_IRQ_MASK = 3'd7;

  // CTRL bit positions
  localparam int c_CTRL_START_WR = 0;
  localparam int c_CTRL_START_RD = 1;
  localparam int c_CTRL_BYTE     = 2;
  localparam int c_CTRL_BUS_RST  = 3;
  localparam int c_CTRL_CLR_ERR  = 4;

  // STATUS bit positions
  localparam int c_STAT_BUSY       = 0;
  localparam int c_STAT_DONE       = 1;
  localparam int c_STAT_TIMEOUT    = 2;
  localparam int c_STAT_OVERRUN    = 3;
  localparam int c_STAT_RST_ACTIVE = 4;

  // TIMING reset value: STROBE=3, SETUP=1
  localparam logic [7:0] c_STROBE_RST = 8'd3;
  localparam logic [3:0] c_SETUP_RST  = 4'd1;

  // Cycle sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } cyc_state_t;

  // A programmed length of N cycles loads a down-counter with N-1;
  // a length of 0 behaves as 1.
  function automatic logic [7:0] len_to_cnt(input logic [7:0] len);
    return (len == 8'd0) ? 8'd0 : (len - 8'd1);
  endfunction

endpackage : isa_bridge_pkg
`default_nettype wire

// File: rtl/isa_cycle_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : isa_cycle_fsm                                          |
// | Description : ISA IOR/IOW cycle sequencer IDLE->SETUP->STROBE->HOLD. |
// |               Latches address/data/mode/timing on i_start, runs the  |
// |               setup and strobe counters, stretches the strobe while  |
// |               IOCHRDY is low and aborts after TIMEOUT_CYC waits.     |
// | Ports       : clk, rst          - clock, sync active-high reset      |
// |               i_start, i_start_wr, i_byte - accepted start request   |
// |               i_addr, i_dout, i_strobe, i_setup - cycle parameters   |
// |               i_iochrdy, i_din  - card ready and pad read data       |
// |               o_a, o_d_out, o_d_oe, o_ior_n, o_iow_n - bus outputs   |
// |               o_busy, o_hold, o_timeout, o_din - status to top       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module isa_cycle_fsm #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_start_wr,
  input  logic              i_byte,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_dout,
  input  logic [7:0]        i_strobe,
  input  logic [3:0]        i_setup,
  input  logic              i_iochrdy,
  input  logic [DATA_W-1:0] i_din,
  output logic [ADDR_W-1:0] o_a,
  output logic [DATA_W-1:0] o_d_out,
  output logic              o_d_oe,
  output logic              o_ior_n,
  output logic              o_iow_n,
  output logic              o_busy,
  output logic              o_hold,
  output logic              o_timeout,
  output logic [DATA_W-1:0] o_din
);
  import isa_bridge_pkg::*;

  localparam int                c_WAIT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(TIMEOUT_CYC);

  cyc_state_t          r_state;
  logic [ADDR_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_d_out;
  logic                r_d_oe;
  logic                r_ior_n;
  logic                r_iow_n;
  logic [7:0]          r_cnt;
  logic [7:0]          r_strobe_len;
  logic [c_WAIT_W-1:0] r_wait;
  logic                r_is_wr;
  logic                r_byte;
  logic                r_timeout;
  logic [DATA_W-1:0]   r_din;

  logic [DATA_W-1:0]   w_dout_m;
  logic [DATA_W-1:0]   w_din_m;

  // Byte transfers only use the low lane; upper lane bits are forced to 0.
  always_comb begin
    w_dout_m = i_dout;
    if (i_byte) begin
      for (int i = 8; i < DATA_W; i++) w_dout_m[i] = 1'b0;
    end
  end

  always_comb begin
    w_din_m = i_din;
    if (r_byte) begin
      for (int i = 8; i < DATA_W; i++) w_din_m[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_a          <= '0;
      r_d_out      <= '0;
      r_d_oe       <= 1'b0;
      r_ior_n      <= 1'b1;
      r_iow_n      <= 1'b1;
      r_cnt        <= '0;
      r_strobe_len <= '0;
      r_wait       <= '0;
      r_is_wr      <= 1'b0;
      r_byte       <= 1'b0;
      r_timeout    <= 1'b0;
      r_din        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state      <= ST_SETUP;
            r_a          <= i_addr;
            r_d_out      <= w_dout_m;
            r_d_oe       <= i_start_wr;
            r_is_wr      <= i_start_wr;
            r_byte       <= i_byte;
            r_strobe_len <= i_strobe;
            r_cnt        <= len_to_cnt({4'd0, i_setup});
            r_timeout    <= 1'b0;
          end
        end

        ST_SETUP: begin
          if (r_cnt == 8'd0) begin
            r_state <= ST_STROBE;
            r_ior_n <= r_is_wr;
            r_iow_n <= ~r_is_wr;
            r_cnt   <= len_to_cnt(r_strobe_len);
            r_wait  <= '0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        ST_STROBE: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else if (i_iochrdy || (r_wait == c_WAIT_MAX)) begin
            // Last strobe cycle: release strobe, capture read data.
            r_state <= ST_HOLD;
            r_ior_n <= 1'b1;
            r_iow_n <= 1'b1;
            if (!i_iochrdy) r_timeout <= 1'b1;
            if (!r_is_wr)   r_din     <= w_din_m;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end

        ST_HOLD: begin
          r_state <= ST_IDLE;
          r_d_oe  <= 1'b0;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_a       = r_a;
  assign o_d_out   = r_d_out;
  assign o_d_oe    = r_d_oe;
  assign o_ior_n   = r_ior_n;
  assign o_iow_n   = r_iow_n;
  assign o_busy    = (r_state != ST_IDLE);
  assign o_hold    = (r_state == ST_HOLD);
  assign o_timeout = r_timeout;
  assign o_din     = r_din;

endmodule : isa_cycle_fsm
`default_nettype wire

// File: rtl/isa_io_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : isa_io_bridge                                          |
// | Description : Avalon-MM to ISA I/O cycle engine for the CT2960       |
// |               riser. Register file, CTRL decode, bus RESET pulse     |
// |               timer and IRQ capture; the bus cycle itself runs in    |
// |               isa_cycle_fsm.                                         |
// | Config      : ISA_IO_BRIDGE_IRQ_EN - builds IRQ sync, IRQ_PEND,      |
// |               IRQ_MASK and irq; otherwise irq=0, regs 6/7 read 0.    |
// | Ports       : clk_50MHz, global_reset - clock, sync active-high rst  |
// |               write, read, address, writedata, readdata - Avalon-MM  |
// |               A, d_out, d_oe, d_in, IOR, IOW, AEN, RESET, iochrdy    |
// |                                    - ISA edge connector              |
// |               irq_in, irq          - raw IRQ lines, HPS interrupt    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module isa_io_bridge #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,   // 8 or 16
  parameter int NUM_IRQ     = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int RESET_CYC   = 500
) (
  input  logic               clk_50MHz,
  input  logic               global_reset,
  input  logic               write,
  input  logic               read,
  input  logic [2:0]         address,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic [ADDR_W-1:0]  A,
  output logic [DATA_W-1:0]  d_out,
  output logic               d_oe,
  input  logic [DATA_W-1:0]  d_in,
  output logic               IOR,
  output logic               IOW,
  output logic               AEN,
  output logic               RESET,
  input  logic               iochrdy,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq
);
  import isa_bridge_pkg::*;

  localparam int               c_RST_W    = $clog2(RESET_CYC + 1);
  localparam logic [c_RST_W-1:0] c_RST_LOAD = c_RST_W'(RESET_CYC - 1);

  logic [DATA_W-1:0]  r_dout;
  logic [ADDR_W-1:0]  r_addr;
  logic [7:0]         r_strobe_len;
  logic [3:0]         r_setup_len;
  logic               r_done;
  logic               r_timeout;
  logic               r_overrun;
  logic               r_reset;
  logic [c_RST_W-1:0] r_rst_cnt;
  logic [31:0]        r_readdata;

  logic               w_busy;
  logic               w_fsm_hold;
  logic               w_fsm_to;
  logic [DATA_W-1:0]  w_din;
  logic               w_ctrl_wr;
  logic               w_start_req;
  logic               w_rst_req;
  logic               w_clr_err;
  logic               w_idle;
  logic               w_start_acc;
  logic               w_rst_acc;
  logic               w_overrun_evt;
  logic [31:0]        w_status;
  logic [31:0]        w_pend_rd;
  logic [31:0]        w_mask_rd;
  logic [31:0]        w_rd_mux;
  logic               w_unused;

  // ---------------------------------------------------------------- CTRL
  assign w_ctrl_wr   = write && (address == c_REG_CTRL);
  assign w_start_req = w_ctrl_wr && (writedata[c_CTRL_START_WR] || writedata[c_CTRL_START_RD]);
  assign w_rst_req   = w_ctrl_wr && writedata[c_CTRL_BUS_RST];
  assign w_clr_err   = w_ctrl_wr && writedata[c_CTRL_CLR_ERR];
  assign w_idle      = !w_busy && !r_reset;
  assign w_start_acc = w_start_req && w_idle;
  // A START in the same write wins the bus; the RESET request is dropped.
  assign w_rst_acc   = w_rst_req && w_idle && !w_start_req;
  assign w_overrun_evt = ((w_start_req || w_rst_req) && !w_idle)
                       || (w_start_req && w_rst_req);

  isa_cycle_fsm #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_cycle_fsm (
    .clk        (clk_50MHz),
    .rst        (global_reset),
    .i_start    (w_start_acc),
    .i_start_wr (writedata[c_CTRL_START_WR]),
    .i_byte     (writedata[c_CTRL_BYTE]),
    .i_addr     (r_addr),
    .i_dout     (r_dout),
    .i_strobe   (r_strobe_len),
    .i_setup    (r_setup_len),
    .i_iochrdy  (iochrdy),
    .i_din      (d_in),
    .o_a        (A),
    .o_d_out    (d_out),
    .o_d_oe     (d_oe),
    .o_ior_n    (IOR),
    .o_iow_n    (IOW),
    .o_busy     (w_busy),
    .o_hold     (w_fsm_hold),
    .o_timeout  (w_fsm_to),
    .o_din      (w_din)
  );

  // This block is the only master on the riser bus, so AEN stays low.
  assign AEN   = 1'b0;
  assign RESET = r_reset;

  // ------------------------------------------------------ register file
  always_ff @(posedge clk_50MHz) begin
    if (global_reset) begin
      r_dout       <= '0;
      r_addr       <= '0;
      r_strobe_len <= c_STROBE_RST;
      r_setup_len  <= c_SETUP_RST;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_overrun    <= 1'b0;
      r_reset      <= 1'b0;
      r_rst_cnt    <= '0;
      r_readdata   <= '0;
    end else begin
      if (write) begin
        case (address)
          c_REG_DOUT:   r_dout <= writedata[DATA_W-1:0];
          c_REG_ADDR:   r_addr <= writedata[ADDR_W-1:0];
          c_REG_TIMING: begin
            r_strobe_len <= writedata[7:0];
            r_setup_len  <= writedata[11:8];
          end
          default: ;
        endcase
      end

      if (w_clr_err) begin
        r_timeout <= 1'b0;
        r_overrun <= 1'b0;
      end

      // DONE/TIMEOUT are published on the edge that leaves HOLD.
      if (w_start_acc) begin
        r_done    <= 1'b0;
        r_timeout <= 1'b0;
      end else if (w_fsm_hold) begin
        r_done <= 1'b1;
        if (w_fsm_to) r_timeout <= 1'b1;
      end

      if (w_overrun_evt) r_overrun <= 1'b1;

      // Bus RESET pulse: high for exactly RESET_CYC clocks.
      if (w_rst_acc) begin
        r_reset   <= 1'b1;
        r_rst_cnt <= c_RST_LOAD;
      end else if (r_reset) begin
        if (r_rst_cnt == '0) r_reset   <= 1'b0;
        else                 r_rst_cnt <= r_rst_cnt - 1'b1;
      end

      if (read) r_readdata <= w_rd_mux;
    end
  end

  always_comb begin
    w_status = '0;
    w_status[c_STAT_BUSY]       = w_busy;
    w_status[c_STAT_DONE]       = r_done;
    w_status[c_STAT_TIMEOUT]    = r_timeout;
    w_status[c_STAT_OVERRUN]    = r_overrun;
    w_status[c_STAT_RST_ACTIVE] = r_reset;
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      c_REG_DOUT:     w_rd_mux = 32'(r_dout);
      c_REG_ADDR:     w_rd_mux = 32'(r_addr);
      c_REG_TIMING:   w_rd_mux = {20'd0, r_setup_len, r_strobe_len};
      c_REG_STATUS:   w_rd_mux = w_status;
      c_REG_DIN:      w_rd_mux = 32'(w_din);
      c_REG_IRQ_PEND: w_rd_mux = w_pend_rd;
      c_REG_IRQ_MASK: w_rd_mux = w_mask_rd;
      default:        w_rd_mux = '0;
    endcase
  end

  assign readdata = r_readdata;

  // ---------------------------------------------------------------- IRQ
`ifdef ISA_IO_BRIDGE_IRQ_EN
  logic [NUM_IRQ-1:0] r_irq_s1;
  logic [NUM_IRQ-1:0] r_irq_s2;
  logic [NUM_IRQ-1:0] r_irq_s3;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] r_mask;
  logic               r_irq;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_w1c;
  logic [NUM_IRQ-1:0] w_pend_next;

  assign w_rise = r_irq_s2 & ~r_irq_s3;
  assign w_w1c  = (write && (address == c_REG_IRQ_PEND)) ? writedata[NUM_IRQ-1:0] : '0;
  // Clear first, then set: a new edge in the same cycle as a W1C survives.
  assign w_pend_next = (r_pend & ~w_w1c) | w_rise;

  always_ff @(posedge clk_50MHz) begin
    if (global_reset) begin
      r_irq_s1 <= '0;
      r_irq_s2 <= '0;
      r_irq_s3 <= '0;
      r_pend   <= '0;
      r_mask   <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_irq_s1 <= irq_in;
      r_irq_s2 <= r_irq_s1;
      r_irq_s3 <= r_irq_s2;
      r_pend   <= w_pend_next;
      if (write && (address == c_REG_IRQ_MASK)) r_mask <= writedata[NUM_IRQ-1:0];
      // Built from the next PEND value so irq rises with the PEND bit.
      r_irq    <= |(w_pend_next & r_mask);
    end
  end

  assign w_pend_rd = 32'(r_pend);
  assign w_mask_rd = 32'(r_mask);
  assign irq       = r_irq;
  assign w_unused  = ^writedata;
`else
  assign w_pend_rd = '0;
  assign w_mask_rd = '0;
  assign irq       = 1'b0;
  assign w_unused  = ^{writedata, irq_in};
`endif

endmodule : isa_io_bridge
`default_nettype wire

// File: tb/tb_isa_io_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_isa_io_bridge                                       |
// | Description : Self-checking bench for isa_io_bridge: register vector |
// |               table, then write/read/timeout/overrun/byte/IRQ/bus    |
// |               RESET sequences. Register reads go through a queue of  |
// |               expected values popped when readdata is produced.      |
// |               Honours ISA_IO_BRIDGE_IRQ_EN for IRQ expectations.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_isa_io_bridge;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;
  localparam int NUM_IRQ     = 4;
  localparam int TIMEOUT_CYC = 1024;
  localparam int RESET_CYC   = 500;

`ifdef ISA_IO_BRIDGE_IRQ_EN
  localparam bit c_IRQ_ON = 1'b1;
`else
  localparam bit c_IRQ_ON = 1'b0;
`endif

  localparam logic [2:0] R_DOUT = 3'd0, R_ADDR = 3'd1, R_CTRL = 3'd2, R_TIM = 3'd3;
  localparam logic [2:0] R_STAT = 3'd4, R_DIN = 3'd5, R_PEND = 3'd6, R_MASK = 3'd7;

  logic               clk_50MHz = 1'b0;
  logic               global_reset = 1'b1;
  logic               write = 1'b0;
  logic               read = 1'b0;
  logic [2:0]         address = '0;
  logic [31:0]        writedata = '0;
  logic [31:0]        readdata;
  logic [ADDR_W-1:0]  A;
  logic [DATA_W-1:0]  d_out;
  logic               d_oe;
  logic [DATA_W-1:0]  d_in = '0;
  logic               IOR, IOW, AEN, RESET;
  logic               iochrdy = 1'b1;
  logic [NUM_IRQ-1:0] irq_in = '0;
  logic               irq;

  isa_io_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_IRQ(NUM_IRQ),
    .TIMEOUT_CYC(TIMEOUT_CYC), .RESET_CYC(RESET_CYC)
  ) dut (
    .clk_50MHz(clk_50MHz), .global_reset(global_reset),
    .write(write), .read(read), .address(address),
    .writedata(writedata), .readdata(readdata),
    .A(A), .d_out(d_out), .d_oe(d_oe), .d_in(d_in),
    .IOR(IOR), .IOW(IOW), .AEN(AEN), .RESET(RESET),
    .iochrdy(iochrdy), .irq_in(irq_in), .irq(irq)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  // Bus activity counters, sampled on the falling edge.
  int iow_lo = 0, ior_lo = 0, oe_hi = 0, rst_hi = 0;
  always @(negedge clk_50MHz) begin
    if (!IOW)  iow_lo++;
    if (!IOR)  ior_lo++;
    if (d_oe)  oe_hi++;
    if (RESET) rst_hi++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_bad = 0;

  typedef struct { logic [2:0] addr; logic [31:0] exp; } rd_exp_t;
  rd_exp_t sb[$];

  typedef struct { bit is_wr; logic [2:0] addr; logic [31:0] data; } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input bit w, input logic [2:0] a, input logic [31:0] d);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk_50MHz);
    address = a; writedata = d; write = 1'b1;
    @(posedge clk_50MHz);
    #1 write = 1'b0;
  endtask

  // Expected value is queued as the read is issued and checked when
  // readdata appears one clock later.
  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp);
    rd_exp_t e;
    @(negedge clk_50MHz);
    address = a; read = 1'b1;
    e.addr = a; e.exp = exp;
    sb.push_back(e);
    @(posedge clk_50MHz);
    #1 read = 1'b0;
    @(negedge clk_50MHz);
    e = sb.pop_front();
    n_vec++;
    if (readdata !== e.exp) begin
      n_bad++;
      $display("FAIL rd_reg%0d: got 0x%08h expected 0x%08h", e.addr, readdata, e.exp);
    end
  endtask

  task automatic wait_done(input int bound, input string nm, output int cyc);
    cyc = 0;
    while (cyc < bound && !dut.r_done) begin
      @(posedge clk_50MHz);
      #1 cyc++;
    end
    if (!dut.r_done) begin
      n_vec++; n_bad++;
      $display("FAIL %s: DONE not seen within %0d clocks", nm, bound);
    end
  endtask

  int cyc, s_iow, s_ior, s_oe, s_rst, k;

  initial begin
    // ------------------------------------------------------------ reset
    repeat (3) @(posedge clk_50MHz);
    @(negedge clk_50MHz);
    global_reset = 1'b0;
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_A",        32'(A), 32'h0);
    chk("rst_d_out",    32'(d_out), 32'h0);
    chk("rst_bus_ctl",  {28'd0, d_oe, IOR, IOW, AEN}, {28'd0, 4'b0110});
    chk("rst_RESET_irq", {30'd0, RESET, irq}, 32'h0);

    // ------------------------------------------------- register table
    add_vec(0, R_DOUT, 32'h0);
    add_vec(0, R_ADDR, 32'h0);
    add_vec(0, R_TIM,  32'h103);
    add_vec(0, R_STAT, 32'h0);
    add_vec(0, R_DIN,  32'h0);
    add_vec(0, R_PEND, 32'h0);
    add_vec(0, R_MASK, 32'h0);
    add_vec(1, R_DOUT, 32'h0001_A55A);
    add_vec(0, R_DOUT, 32'h0000_A55A);
    add_vec(1, R_ADDR, 32'h000F_0220);
    add_vec(0, R_ADDR, 32'h0000_0220);
    add_vec(1, R_TIM,  32'h000F_FFFF);
    add_vec(0, R_TIM,  32'h0000_0FFF);
    add_vec(1, R_TIM,  32'h0000_0103);
    add_vec(0, R_TIM,  32'h0000_0103);
    add_vec(1, R_STAT, 32'hFFFF_FFFF);
    add_vec(0, R_STAT, 32'h0);
    add_vec(1, R_DIN,  32'h0000_FFFF);
    add_vec(0, R_DIN,  32'h0);
    add_vec(1, R_MASK, 32'h0000_00FF);
    add_vec(0, R_MASK, c_IRQ_ON ? 32'hF : 32'h0);
    add_vec(1, R_MASK, 32'h0);
    add_vec(0, R_MASK, 32'h0);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_wr) bus_write(vecs[i].addr, vecs[i].data);
      else               bus_read(vecs[i].addr, vecs[i].data);
    end

    // ------------------------------------------------------ write cycle
    s_iow = iow_lo; s_oe = oe_hi;
    bus_write(R_CTRL, 32'h1);
    wait_done(50, "wr_done", cyc);
    chk("wr_cycle_len", 32'(cyc), 32'd5);
    chk("wr_iow_low",   32'(iow_lo - s_iow), 32'd3);
    chk("wr_d_oe_high", 32'(oe_hi - s_oe), 32'd5);
    chk("wr_A",         32'(A), 32'h220);
    chk("wr_d_out",     32'(d_out), 32'hA55A);
    chk("wr_idle_ctl",  {29'd0, d_oe, IOW, IOR}, {29'd0, 3'b011});
    bus_read(R_STAT, 32'h2);

    // ------------------------------------------- read cycle, wait states
    d_in = 16'h1234; iochrdy = 1'b0;
    s_ior = ior_lo;
    bus_write(R_CTRL, 32'h2);
    k = 0;
    do begin @(negedge clk_50MHz); k++; end while (IOR && k < 20);
    chk("rd_ior_asserted", 32'(IOR), 32'h0);
    repeat (9) @(negedge clk_50MHz);
    iochrdy = 1'b1;
    wait_done(50, "rd_done", cyc);
    chk("rd_ior_low", 32'(ior_lo - s_ior), 32'd10);
    bus_read(R_DIN,  32'h1234);
    bus_read(R_STAT, 32'h2);

    // ---------------------------------------------------------- timeout
    iochrdy = 1'b0;
    s_ior = ior_lo;
    bus_write(R_CTRL, 32'h2);
    wait_done(TIMEOUT_CYC + 100, "to_done", cyc);
    chk("to_ior_low", 32'(ior_lo - s_ior), 32'(3 + TIMEOUT_CYC));
    chk("to_ior_high", 32'(IOR), 32'h1);
    bus_read(R_STAT, 32'h6);
    iochrdy = 1'b1;
    bus_write(R_CTRL, 32'h10);
    bus_read(R_STAT, 32'h2);

    // -------------------------------------------- byte read + overrun
    d_in = 16'hBEEF;
    s_ior = ior_lo; s_iow = iow_lo;
    bus_write(R_CTRL, 32'h6);
    bus_write(R_CTRL, 32'h1);
    wait_done(50, "ov_done", cyc);
    repeat (8) @(negedge clk_50MHz);
    chk("ov_ior_low", 32'(ior_lo - s_ior), 32'd3);
    chk("ov_no_write", 32'(iow_lo - s_iow), 32'd0);
    bus_read(R_DIN,  32'h00EF);
    bus_read(R_STAT, 32'hA);
    bus_write(R_CTRL, 32'h10);
    bus_read(R_STAT, 32'h2);

    // -------------------------------------------------------------- IRQ
    bus_write(R_MASK, 32'h4);
    @(negedge clk_50MHz);
    irq_in[2] = 1'b1;
    @(posedge clk_50MHz); @(posedge clk_50MHz); #1;
    chk("irq_before_3clk", 32'(irq), 32'h0);
    @(posedge clk_50MHz); #1;
    chk("irq_after_3clk", 32'(irq), c_IRQ_ON ? 32'h1 : 32'h0);
    bus_read(R_PEND, c_IRQ_ON ? 32'h4 : 32'h0);
    bus_write(R_PEND, 32'h4);
    bus_read(R_PEND, 32'h0);
    chk("irq_cleared", 32'(irq), 32'h0);
    // Masked-off line sets PEND but not irq.
    @(negedge clk_50MHz);
    irq_in[1] = 1'b1;
    repeat (5) @(negedge clk_50MHz);
    chk("irq_masked", 32'(irq), 32'h0);
    bus_read(R_PEND, c_IRQ_ON ? 32'h2 : 32'h0);
    bus_write(R_PEND, 32'h2);
    irq_in = '0;
    repeat (5) @(negedge clk_50MHz);
    // New edge on irq_in[2] lands in the same cycle as its W1C.
    irq_in[2] = 1'b1;
    @(negedge clk_50MHz);
    @(negedge clk_50MHz);
    address = R_PEND; writedata = 32'h4; write = 1'b1;
    @(posedge clk_50MHz);
    #1 write = 1'b0;
    bus_read(R_PEND, c_IRQ_ON ? 32'h4 : 32'h0);
    chk("irq_set_wins", 32'(irq), c_IRQ_ON ? 32'h1 : 32'h0);
    irq_in = '0;

    // ------------------------------------------------------ bus RESET
    s_rst = rst_hi; s_iow = iow_lo;
    bus_write(R_CTRL, 32'h8);
    repeat (5) @(negedge clk_50MHz);
    bus_write(R_CTRL, 32'h1);
    bus_read(R_STAT, 32'h1A);
    k = 0;
    do begin @(negedge clk_50MHz); k++; end while (RESET && k < RESET_CYC + 50);
    chk("busrst_width", 32'(rst_hi - s_rst), 32'(RESET_CYC));
    chk("busrst_no_cycle", 32'(iow_lo - s_iow), 32'd0);
    bus_read(R_STAT, 32'hA);

    // ------------------------------------ global_reset mid pulse / cycle
    bus_write(R_CTRL, 32'h8);
    repeat (10) @(negedge clk_50MHz);
    chk("grst_pulse_on", 32'(RESET), 32'h1);
    global_reset = 1'b1;
    @(posedge clk_50MHz); #1;
    chk("grst_pulse_off", 32'(RESET), 32'h0);
    @(negedge clk_50MHz);
    global_reset = 1'b0;
    bus_read(R_STAT, 32'h0);
    bus_read(R_TIM,  32'h103);
    bus_write(R_ADDR, 32'h3F8);
    bus_write(R_CTRL, 32'h1);
    @(negedge clk_50MHz);
    @(negedge clk_50MHz);
    chk("grst_mid_iow", 32'(IOW), 32'h0);
    global_reset = 1'b1;
    @(posedge clk_50MHz); #1;
    chk("grst_mid_ctl", {29'd0, IOW, IOR, d_oe}, {29'd0, 3'b110});
    chk("grst_mid_A", 32'(A), 32'h0);
    @(negedge clk_50MHz);
    global_reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_isa_io_bridge
`default_nettype wire

// File: doc/isa_io_bridge.md
# isa_io_bridge

Parametrised ISA I/O cycle engine for the CT2960 riser. It sits between the HPS lightweight Avalon-MM slave port and the ISA edge connector. The HPS loads address, data and timing registers; the block then runs a complete IOR/IOW cycle with programmable setup and strobe lengths, IOCHRDY wait-state extension and a timeout. It also supports 8/16-bit transfers, a timed bus RESET pulse and latched, maskable IRQ capture.

## Interface
Parameters:
- ADDR_W, 16, ISA address width driven on `A`.
- DATA_W, 16, ISA data width; legal values are 8 or 16.
- NUM_IRQ, 4, number of IRQ inputs captured.
- TIMEOUT_CYC, 1024, maximum number of strobe cycles while IOCHRDY is low.
- RESET_CYC, 500, width in clocks of the bus RESET pulse.

Ports:
- clk_50MHz  in  1  system clock; all logic runs on the rising edge.
- global_reset  in  1  synchronous, active-high reset.
- write, read  in  1  Avalon-MM strobes.
- address  in  3  register word select.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- A  out  ADDR_W  ISA address.
- d_out  out  DATA_W  write data to the pad.
- d_oe  out  1  pad drive enable.
- d_in  in  DATA_W  data from the pad.
- IOR, IOW  out  1  active-low strobes.
- AEN  out  1  address enable, driven 0 while this block owns the bus.
- RESET  out  1  active-high ISA reset.
- iochrdy  in  1  high means the card is ready.
- irq_in  in  NUM_IRQ  raw IRQ lines.
- irq  out  1  interrupt to the HPS.

## Operation
Register map (word address):
- 0 DOUT, RW: [DATA_W-1:0].
- 1 ADDR, RW: [ADDR_W-1:0].
- 2 CTRL, W: bit0 START_WR, bit1 START_RD, bit2 BYTE, bit3 BUS_RST, bit4 CLR_ERR. Bits 0, 1, 3 and 4 are self-clearing pulses; BYTE is sampled when a start is accepted.
- 3 TIMING, RW: [7:0] STROBE cycles (0 is treated as 1); [11:8] SETUP cycles.
- 4 STATUS, R: bit0 BUSY, bit1 DONE, bit2 TIMEOUT, bit3 OVERRUN, bit4 RST_ACTIVE.
- 5 DIN, R: last captured read data.
- 6 IRQ_PEND: R; write 1 to clear a bit.
- 7 IRQ_MASK: RW.

Cycle FSM, states IDLE → SETUP → STROBE → HOLD → IDLE:
- IDLE: a START accepted here latches ADDR, DOUT, BYTE and TIMING, sets BUSY and clears DONE/TIMEOUT. If START_WR and START_RD are both set, the write is performed.
- SETUP: `A` is driven, d_oe=1 for writes. Stay SETUP cycles, then go to STROBE. With SETUP=0 the state lasts one cycle.
- STROBE: IOR or IOW is low. A counter runs for STROBE cycles.
  - After the count expires, stay in STROBE while iochrdy=0.
  - If iochrdy is still 0 after TIMEOUT_CYC extra cycles, set TIMEOUT and go to HOLD.
  - For reads, capture d_in on the last STROBE cycle.
  - When BYTE=1 or DATA_W=8, bits [15:8] of DIN are zero and d_out[15:8] is zero.
- HOLD: the strobe is high while `A` and d_out stay held. This lasts one cycle, then IDLE with DONE set and BUSY cleared.

Bus control rules:
- A START received while BUSY or RST_ACTIVE is ignored and sets OVERRUN.
- CLR_ERR clears TIMEOUT and OVERRUN.
- BUS_RST accepted in IDLE drives RESET=1 for RESET_CYC clocks and sets RST_ACTIVE. BUS_RST received while BUSY is ignored and sets OVERRUN.

## Timing
- Reset values:
  - readdata=0, A=0, d_out=0, d_oe=0.
  - IOR=1, IOW=1, AEN=0, RESET=0, irq=0.
  - All registers 0, except TIMING: STROBE=3, SETUP=1.
- Writes take effect on the edge where `write` is sampled. readdata is valid the cycle after `read` (read latency 1).
- Cycle length, from the edge after the START write to the edge DONE rises: max(SETUP,1) + max(STROBE,1) + wait + 1 clocks.
- IRQ handling:
  - irq_in passes through a 2-FF synchroniser.
  - A rising edge of the synchronised line sets the matching PEND bit.
  - If a set and a W1C hit the same bit in the same cycle, the set wins.
  - irq is registered: irq = |(PEND & MASK).
- global_reset in the middle of a cycle returns the FSM to IDLE and the strobes to 1 on the next edge. It also aborts a RESET pulse.

## Configuration
- ISA_IO_BRIDGE_IRQ_EN defined: the IRQ synchroniser, IRQ_PEND, IRQ_MASK and the irq output are built.
- Macro undefined: irq is tied to 0, addresses 6 and 7 read as 0 and ignore writes, and irq_in is unused.

## Structure
- Shared package isa_bridge_pkg holds:
  - the register address localparams;
  - the CTRL and STATUS bit-index constants;
  - the FSM state enum.
- One sub-module, isa_cycle_fsm, holds the SETUP/STROBE/HOLD sequencer with its counters and timeout.
- The top level holds the register file, the RESET pulse counter and the IRQ logic.

## Test plan
- Write cycle: ADDR=0x220, DOUT=0xA55A, TIMING=0x103, START_WR → `A`=0x220, IOW low exactly 3 clocks, d_oe high from SETUP through HOLD, DONE after 5 clocks.
- Read cycle with IOCHRDY: iochrdy held low 7 clocks beyond STROBE, d_in=0x1234 → IOR low for 10 clocks, DIN=0x1234, TIMEOUT=0.
- Timeout: iochrdy stuck at 0 → TIMEOUT=1 after STROBE+TIMEOUT_CYC strobe clocks, DONE=1, IOR back to 1; CLR_ERR then clears TIMEOUT.
- Overrun and byte mode: START_RD with BYTE=1, d_in=0xBEEF → DIN=0x00EF; a second START issued mid-cycle sets OVERRUN and does not start a new cycle.
- IRQ: MASK=0b0100, pulse irq_in[2] → PEND=0b0100 and irq=1 three clocks after the edge; W1C issued in the same cycle as a new edge on irq_in[2] leaves PEND set.
- BUS_RST: RESET high exactly RESET_CYC clocks; START during the pulse sets OVERRUN; global_reset during the pulse drops RESET on the next edge.
